algo_1rw_port_arb: RTL and testbench

ALGO_1RW_PORT_ARB -- requirements
Module: algo_1rw_port_arb

---
 rtl/algo_1rw_port_arb_pkg.sv | 16 +
 rtl/algo_1rw_tag_pipe.sv | 30 +++
 rtl/algo_1rw_port_arb.sv | 137 +++++++++++++
 tb/tb_algo_1rw_port_arb.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/algo_1rw_port_arb_pkg.sv
// Shared types for the 1RW port arbiter: requester ids and read-tag records.
package algo_1rw_port_arb_pkg;

  typedef enum logic {
    ReqA = 1'b0,
    ReqB = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } tag_t;

  localparam tag_t TagIdle = '{valid: 1'b0, id: ReqA};

endpackage

// File: rtl/algo_1rw_tag_pipe.sv
// Fixed-depth shift register of read tags; output lines up with the core read return.
module algo_1rw_tag_pipe
  import algo_1rw_port_arb_pkg::*;
#(
  parameter int unsigned RD_DELAY = 2
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage_q [RD_DELAY];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(RD_DELAY); i++) begin
        stage_q[i] <= TagIdle;
      end
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < int'(RD_DELAY); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_out = stage_q[RD_DELAY-1];

endmodule

// File: rtl/algo_1rw_port_arb.sv
// Two-requester round-robin arbiter onto a single 1RW core port, with refresh slots
// and tagged routing of read returns.
module algo_1rw_port_arb
  import algo_1rw_port_arb_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned BITADDR  = 13,
  parameter int unsigned RD_DELAY = 2,
  parameter int unsigned REFRESH  = 1,
  parameter int unsigned REFFREQ  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ready,
  input  logic               a_req,
  input  logic               a_write,
  input  logic [BITADDR-1:0] a_addr,
  input  logic [WIDTH-1:0]   a_din,
  input  logic               b_req,
  input  logic               b_write,
  input  logic [BITADDR-1:0] b_addr,
  input  logic [WIDTH-1:0]   b_din,
  output logic               a_gnt,
  output logic               b_gnt,
  output logic               rw_read,
  output logic               rw_write,
  output logic [BITADDR-1:0] rw_addr,
  output logic [WIDTH-1:0]   rw_din,
  output logic               refr,
  input  logic               rw_vld,
  input  logic [WIDTH-1:0]   rw_dout,
  output logic               a_vld,
  output logic               b_vld,
  output logic [WIDTH-1:0]   a_dout,
  output logic [WIDTH-1:0]   b_dout,
  output logic               rsp_err
);

  localparam int unsigned    CntW    = $clog2(REFFREQ);
  localparam logic [CntW-1:0] CntLast = CntW'(REFFREQ - 1);

  logic [CntW-1:0]  ref_cnt_q, ref_cnt_d;
  logic             hold;
  logic             prio_b_q, prio_b_d;
  req_id_e          rw_id_q;
  logic [WIDTH-1:0] a_dout_q, b_dout_q;
  tag_t             tag_in, tag_out;
  logic             ret_ok;

  // Refresh slot: the last count of each period blocks grants.
  always_comb begin
    hold      = (REFRESH != 0) && ready && (ref_cnt_q == CntLast);
    ref_cnt_d = '0;
    if ((REFRESH != 0) && ready) begin
      ref_cnt_d = (ref_cnt_q == CntLast) ? '0 : ref_cnt_q + 1'b1;
    end
  end

  // prio_b_q set means A was granted most recently, so B wins a tie.
  always_comb begin
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    prio_b_d = prio_b_q;
    if (ready && !hold) begin
      if (a_req && b_req) begin
        a_gnt = !prio_b_q;
        b_gnt = prio_b_q;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
    if (a_gnt) begin
      prio_b_d = 1'b1;
    end else if (b_gnt) begin
      prio_b_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt_q <= '0;
      prio_b_q  <= 1'b0;
      rw_read   <= 1'b0;
      rw_write  <= 1'b0;
      rw_addr   <= '0;
      rw_din    <= '0;
      rw_id_q   <= ReqA;
      refr      <= 1'b0;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      prio_b_q  <= prio_b_d;
      rw_read   <= (a_gnt && !a_write) || (b_gnt && !b_write);
      rw_write  <= (a_gnt && a_write) || (b_gnt && b_write);
      rw_id_q   <= b_gnt ? ReqB : ReqA;
      refr      <= hold;
      if (a_gnt) begin
        rw_addr <= a_addr;
        rw_din  <= a_din;
      end else if (b_gnt) begin
        rw_addr <= b_addr;
        rw_din  <= b_din;
      end
    end
  end

  assign tag_in = '{valid: rw_read, id: rw_id_q};

  algo_1rw_tag_pipe #(
    .RD_DELAY(RD_DELAY)
  ) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  // Returns that disagree with the tag pipe are flagged and dropped.
  assign ret_ok = tag_out.valid && rw_vld;
  assign a_vld  = ret_ok && (tag_out.id == ReqA);
  assign b_vld  = ret_ok && (tag_out.id == ReqB);
  assign a_dout = a_vld ? rw_dout : a_dout_q;
  assign b_dout = b_vld ? rw_dout : b_dout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_dout_q <= '0;
      b_dout_q <= '0;
      rsp_err  <= 1'b0;
    end else begin
      a_dout_q <= a_dout;
      b_dout_q <= b_dout;
      rsp_err  <= rsp_err || (rw_vld != tag_out.valid);
    end
  end

endmodule

// File: tb/tb_algo_1rw_port_arb.sv
// Randomized bench for algo_1rw_port_arb against a cycle-level behavioural model.
module tb_algo_1rw_port_arb;

  localparam int W   = 32;
  localparam int AW  = 13;
  localparam int RD  = 2;
  localparam int REF = 1;
  localparam int RF  = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ready = 1'b0;
  logic          a_req = 1'b0, a_write = 1'b0, b_req = 1'b0, b_write = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [W-1:0]  a_din = '0, b_din = '0;
  logic          a_gnt, b_gnt, rw_read, rw_write, refr, a_vld, b_vld, rsp_err;
  logic [AW-1:0] rw_addr;
  logic [W-1:0]  rw_din, a_dout, b_dout;
  logic          rw_vld = 1'b0;
  logic [W-1:0]  rw_dout = '0;

  algo_1rw_port_arb #(
    .WIDTH(W), .BITADDR(AW), .RD_DELAY(RD), .REFRESH(REF), .REFFREQ(RF)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .a_req(a_req), .a_write(a_write), .a_addr(a_addr), .a_din(a_din),
    .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_din(b_din),
    .a_gnt(a_gnt), .b_gnt(b_gnt),
    .rw_read(rw_read), .rw_write(rw_write), .rw_addr(rw_addr), .rw_din(rw_din),
    .refr(refr), .rw_vld(rw_vld), .rw_dout(rw_dout),
    .a_vld(a_vld), .b_vld(b_vld), .a_dout(a_dout), .b_dout(b_dout),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Core model: returns scheduled by cycle number (mod 64).
  bit         core_vld [64];
  logic [W-1:0] core_dat [64];
  bit         spur = 1'b0;
  bit         ovr_valid = 1'b0;
  logic [W-1:0] ovr_data;

  // Behavioural model state (value seen during the current cycle).
  typedef struct { int due; bit id; } pend_t;
  pend_t        pend [$];
  bit           last_gnt_b = 1'b1;
  int           ready_run = 0;
  bit           e_rw_read = 0, e_rw_write = 0, e_refr = 0, e_rsp_err = 0;
  logic [AW-1:0] e_rw_addr = '0;
  logic [W-1:0]  e_rw_din = '0, e_a_dout = '0, e_b_dout = '0;

  task automatic model_reset();
    pend.delete();
    last_gnt_b = 1'b1;
    ready_run  = 0;
    e_rw_read  = 0; e_rw_write = 0; e_refr = 0; e_rsp_err = 0;
    e_rw_addr  = '0; e_rw_din = '0; e_a_dout = '0; e_b_dout = '0;
  endtask

  task automatic model_cycle();
    bit hold, ga, gb, tagv, tid, xa, xb, w;
    logic [W-1:0] da, db, rdat;
    int due;
    if (!rst) begin
      model_reset();
      chk("rst_rw_read", rw_read, 0);
      chk("rst_rw_write", rw_write, 0);
      chk("rst_rw_addr", rw_addr, 0);
      chk("rst_rw_din", rw_din, 0);
      chk("rst_refr", refr, 0);
      chk("rst_vld", {a_vld, b_vld}, 0);
      chk("rst_a_dout", a_dout, 0);
      chk("rst_b_dout", b_dout, 0);
      chk("rst_rsp_err", rsp_err, 0);
      return;
    end
    hold = (REF != 0) && ready && ((ready_run % RF) == RF - 1);
    ga = 0; gb = 0;
    if (ready && !hold) begin
      if (a_req && b_req) begin
        ga = last_gnt_b;
        gb = !last_gnt_b;
      end else begin
        ga = a_req;
        gb = b_req;
      end
    end
    tagv = (pend.size() > 0) && (pend[0].due == cyc);
    tid  = tagv ? pend[0].id : 1'b0;
    xa   = tagv && rw_vld && !tid;
    xb   = tagv && rw_vld && tid;
    da   = xa ? rw_dout : e_a_dout;
    db   = xb ? rw_dout : e_b_dout;

    chk("a_gnt", a_gnt, ga);
    chk("b_gnt", b_gnt, gb);
    chk("rw_read", rw_read, e_rw_read);
    chk("rw_write", rw_write, e_rw_write);
    chk("rw_addr", rw_addr, e_rw_addr);
    chk("rw_din", rw_din, e_rw_din);
    chk("refr", refr, e_refr);
    chk("a_vld", a_vld, xa);
    chk("b_vld", b_vld, xb);
    chk("a_dout", a_dout, da);
    chk("b_dout", b_dout, db);
    chk("rsp_err", rsp_err, e_rsp_err);

    if (rw_vld != tagv) e_rsp_err = 1;
    if (tagv) void'(pend.pop_front());
    e_a_dout = da;
    e_b_dout = db;
    if (ga || gb) begin
      w          = gb ? b_write : a_write;
      e_rw_read  = !w;
      e_rw_write = w;
      e_rw_addr  = gb ? b_addr : a_addr;
      e_rw_din   = gb ? b_din : a_din;
      last_gnt_b = gb;
      if (!w) begin
        due = cyc + 1 + RD;
        pend.push_back('{due: due, id: gb});
        rdat = $urandom;
        if (ovr_valid) begin
          rdat = ovr_data;
          ovr_valid = 0;
        end
        core_vld[due % 64] = 1'b1;
        core_dat[due % 64] = rdat;
      end
    end else begin
      e_rw_read  = 0;
      e_rw_write = 0;
    end
    e_refr    = hold;
    ready_run = ready ? ready_run + 1 : 0;
  endtask

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic end_cycle();
    int idx;
    idx     = cyc % 64;
    rw_vld  = core_vld[idx] | spur;
    rw_dout = core_vld[idx] ? core_dat[idx] : W'($urandom);
    core_vld[idx] = 1'b0;
    spur    = 1'b0;
    @(negedge clk);
    model_cycle();
  endtask

  task automatic rand_cmd();
    a_addr = AW'($urandom); a_din = $urandom;
    b_addr = AW'($urandom); b_din = $urandom;
  endtask

  int  g0, v0, n_agnt, n_refr, n_bad, n_bvld, k0, alt_bad, n_gnt;
  bit  have_last, last_b;
  logic [W-1:0] v0_data;

  initial begin
    for (int i = 0; i < 64; i++) core_vld[i] = 1'b0;

    // Reset held with ready low.
    for (int i = 0; i < 3; i++) begin
      begin_cycle();
      end_cycle();
    end

    // A reads continuously: refresh slots every RF cycles, first return pinned.
    ovr_valid = 1'b1;
    ovr_data  = 32'hDEADBEEF;
    g0 = -1; v0 = -1; n_agnt = 0; n_refr = 0; n_bad = 0; n_bvld = 0;
    k0 = cyc + 1;
    for (int k = 1; k <= 42; k++) begin
      begin_cycle();
      rst = 1'b1; ready = 1'b1; a_req = 1'b1; a_write = 1'b0;
      rand_cmd();
      if (k == 1) a_addr = 13'h010;
      end_cycle();
      if (a_gnt && g0 < 0) g0 = cyc;
      if (a_vld && v0 < 0) begin
        v0 = cyc;
        v0_data = a_dout;
      end
      if (k <= 36 && a_gnt) n_agnt++;
      if (k >= 7 && refr) n_refr++;
      if (refr && rw_read) n_bad++;
      if (b_vld) n_bvld++;
    end
    chk("first_gnt_cycle", g0, k0);
    chk("first_vld_latency", v0 - g0, RD + 1);
    chk("first_vld_data", v0_data, 32'hDEADBEEF);
    chk("a_gnt_in_36", n_agnt, 30);
    chk("refr_in_36", n_refr, 6);
    chk("refr_with_read", n_bad, 0);
    chk("b_vld_idle", n_bvld, 0);

    // Both requesters read continuously: grants must alternate.
    alt_bad = 0; have_last = 1'b1; last_b = 1'b0;
    for (int k = 0; k < 30; k++) begin
      begin_cycle();
      a_req = 1'b1; b_req = 1'b1; a_write = 1'b0; b_write = 1'b0;
      rand_cmd();
      end_cycle();
      if (a_gnt || b_gnt) begin
        if (have_last && (b_gnt == last_b)) alt_bad++;
        have_last = 1'b1;
        last_b    = b_gnt;
      end
    end
    chk("grants_alternate", alt_bad, 0);

    // Random traffic with ready dropouts.
    for (int k = 0; k < 400; k++) begin
      begin_cycle();
      ready   = ($urandom_range(0, 7) != 0);
      a_req   = $urandom_range(0, 1); b_req   = $urandom_range(0, 1);
      a_write = $urandom_range(0, 1); b_write = $urandom_range(0, 1);
      rand_cmd();
      end_cycle();
    end
    chk("no_err_random", rsp_err, 0);

    // Reads in flight, then ready drops.
    for (int k = 0; k < 2; k++) begin
      begin_cycle();
      ready = 1'b1; a_req = 1'b1; b_req = 1'b1; a_write = 1'b0; b_write = 1'b0;
      rand_cmd();
      end_cycle();
    end
    n_gnt = 0; n_refr = 0;
    for (int k = 0; k < 8; k++) begin
      begin_cycle();
      ready = 1'b0;
      rand_cmd();
      end_cycle();
      if (a_gnt || b_gnt) n_gnt++;
      if (k > 0 && refr) n_refr++;
    end
    chk("no_gnt_ready_low", n_gnt, 0);
    chk("no_refr_ready_low", n_refr, 0);

    // Spurious return with nothing outstanding.
    a_req = 1'b0; b_req = 1'b0;
    begin_cycle();
    spur = 1'b1;
    end_cycle();
    for (int k = 0; k < 5; k++) begin
      begin_cycle();
      end_cycle();
      chk("rsp_err_sticky", rsp_err, 1);
    end

    // Reset clears the flag; reset mid-burst orphans returns.
    begin_cycle();
    rst = 1'b0;
    end_cycle();
    chk("rsp_err_cleared", rsp_err, 0);
    for (int k = 0; k < 3; k++) begin
      begin_cycle();
      rst = 1'b1; ready = 1'b1; a_req = 1'b1; b_req = 1'b1; a_write = 1'b0; b_write = 1'b0;
      rand_cmd();
      end_cycle();
    end
    begin_cycle();
    rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
    end_cycle();
    chk("mid_burst_rst_read", rw_read, 0);
    for (int k = 0; k < 4; k++) begin
      begin_cycle();
      rst = 1'b1;
      end_cycle();
    end
    chk("orphan_return_err", rsp_err, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
